alu_bitserial_seq: RTL and testbench

- Bit-serial issuing controller for the team's 1-bit ALU slice; it is the producer of the 6-bit funct select that the slice's output mux decodes.
- Accepts one 32-bit ALU request over a valid/ready handshake.
- Steps the slice through the operand one bit per cycle, driving select, operand bits, B-invert and carry-in, and reassembling the slice outputs into a result word.
- Handles the two-pass SLT sequence: subtract first, then feed the computed set bit into the slice's `less` input.

---
 rtl/alu_bitserial_seq.sv | 137 +++++++++++++
 tb/tb_alu_bitserial_seq.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/alu_bitserial_seq.sv
// alu_bitserial_seq: issues one request bit-serially through the 1-bit ALU slice.
// SLT uses two passes: a SUB pass, then one FIX cycle that feeds the set bit into the slice's less input.
module alu_bitserial_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [5:0]       req_funct,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [5:0]       slice_sel,
    output logic             slice_a,
    output logic             slice_b,
    output logic             slice_binv,
    output logic             slice_cin,
    output logic             slice_less,
    input  logic             slice_out,
    input  logic             slice_cout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_ovf,
    output logic             rsp_err
);
    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [5:0] F_ADD = 6'd32;
    localparam logic [5:0] F_SUB = 6'd34;
    localparam logic [5:0] F_AND = 6'd36;
    localparam logic [5:0] F_OR  = 6'd37;
    localparam logic [5:0] F_SLT = 6'd42;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state_q, state_d;
    logic [5:0]       funct_q;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic [IW-1:0]    idx_q;
    logic             carry_q, ovf_q, msb_q, err_q;
    logic             supported, arith, sub_op, last;

    assign supported = req_funct inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
    assign sub_op    = (funct_q == F_SUB) || (funct_q == F_SLT);
    assign arith     = sub_op || (funct_q == F_ADD);
    assign last      = idx_q == IW'(WIDTH - 1);

    assign rsp_result = result_q;
    assign rsp_ovf    = ovf_q;
    assign rsp_err    = err_q;
    assign rsp_zero   = (state_q == DONE) && (result_q == '0);

    always_comb begin
        state_d    = state_q;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        slice_sel  = 6'd0;
        slice_a    = 1'b0;
        slice_b    = 1'b0;
        slice_binv = 1'b0;
        slice_cin  = 1'b0;
        slice_less = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = supported ? RUN : DONE;
            end
            RUN: begin
                slice_sel  = (funct_q == F_SLT) ? F_SUB : funct_q;
                slice_a    = a_q[idx_q];
                slice_b    = b_q[idx_q];
                slice_binv = sub_op;
                slice_cin  = (idx_q == '0) ? sub_op : carry_q;
                if (last) state_d = (funct_q == F_SLT) ? FIX : DONE;
            end
            FIX: begin
                slice_sel  = F_SLT;
                slice_a    = a_q[0];
                slice_b    = b_q[0];
                slice_binv = 1'b1;
                slice_cin  = 1'b1;
                slice_less = msb_q ^ ovf_q;
                state_d    = DONE;
            end
            DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            funct_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            msb_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: if (req_valid) begin
                    funct_q  <= req_funct;
                    a_q      <= req_a;
                    b_q      <= req_b;
                    idx_q    <= '0;
                    carry_q  <= 1'b0;
                    ovf_q    <= 1'b0;
                    err_q    <= !supported;
                    result_q <= '0;
                end
                RUN: begin
                    result_q[idx_q] <= slice_out;
                    carry_q         <= slice_cout;
                    idx_q           <= idx_q + 1'b1;
                    // SLT keeps the subtract overflow so FIX can correct the sign bit
                    if (last) begin
                        ovf_q <= arith & (slice_cin ^ slice_cout);
                        msb_q <= slice_out;
                    end
                end
                FIX: begin
                    result_q <= {{(WIDTH-1){1'b0}}, slice_out};
                    ovf_q    <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_bitserial_seq.sv
// tb_alu_bitserial_seq: directed + random requests against a behavioural slice and an arithmetic reference model.
module tb_alu_bitserial_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready;
    logic [5:0]  req_funct = 6'd0;
    logic [31:0] req_a = '0, req_b = '0;
    logic [5:0]  slice_sel;
    logic        slice_a, slice_b, slice_binv, slice_cin, slice_less;
    logic        slice_out, slice_cout;
    logic        rsp_valid, rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic        rsp_zero, rsp_ovf, rsp_err;
    logic        bb, sum;
    int          passed = 0, total = 0;

    alu_bitserial_seq #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_funct(req_funct), .req_a(req_a), .req_b(req_b),
        .slice_sel(slice_sel), .slice_a(slice_a), .slice_b(slice_b),
        .slice_binv(slice_binv), .slice_cin(slice_cin), .slice_less(slice_less),
        .slice_out(slice_out), .slice_cout(slice_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_zero(rsp_zero), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    // 1-bit ALU slice: full adder with B inversion plus output mux keyed by funct
    always_comb begin
        bb         = slice_b ^ slice_binv;
        sum        = slice_a ^ bb ^ slice_cin;
        slice_cout = (slice_a & bb) | (slice_cin & (slice_a ^ bb));
        slice_out  = (slice_sel == 6'd36) ? (slice_a & bb) :
                     (slice_sel == 6'd37) ? (slice_a | bb) :
                     (slice_sel == 6'd32 || slice_sel == 6'd34) ? sum :
                     (slice_sel == 6'd42) ? slice_less : 1'b0;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ov, output logic er);
        r = '0; ov = 1'b0; er = 1'b0;
        case (f)
            6'd36: r = a & b;
            6'd37: r = a | b;
            6'd32: begin r = a + b; ov = (a[31] == b[31]) && (r[31] != a[31]); end
            6'd34: begin r = a - b; ov = (a[31] != b[31]) && (r[31] != a[31]); end
            6'd42: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: er = 1'b1;
        endcase
    endfunction

    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] er;
        logic        eo, ee;
        logic [5:0]  rs;
        int          cyc, bad, lat;
        model(f, a, b, er, eo, ee);
        lat = ee ? 1 : (f == 6'd42) ? 34 : 33;
        rs  = (f == 6'd42) ? 6'd34 : f;
        req_funct = f; req_a = a; req_b = b; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_a = $urandom; req_b = $urandom;
        cyc = 1; bad = 0;
        while (!rsp_valid && cyc < 100) begin
            if (slice_sel !== ((cyc <= 32) ? rs : 6'd42)) bad++;
            if (req_ready !== 1'b0) bad++;
            @(posedge clk); #1;
            cyc++;
        end
        check("latency", 32'(cyc), 32'(lat));
        check("result", rsp_result, er);
        check("zero", 32'(rsp_zero), 32'(er == 0));
        check("ovf", 32'(rsp_ovf), 32'(eo));
        check("err", 32'(rsp_err), 32'(ee));
        check("run_sel", 32'(bad), 0);
        check("done_slice", 32'({slice_sel, slice_a, slice_b, slice_binv, slice_cin, slice_less, req_ready}), 0);
        repeat (hold) begin
            req_valid = 1'b1; req_funct = 6'd32; req_a = $urandom; req_b = $urandom;
            @(posedge clk); #1;
            check("hold_result", rsp_result, er);
            check("hold_flags", 32'({rsp_valid, req_ready, rsp_zero, rsp_ovf, rsp_err}),
                  32'({1'b1, 1'b0, er == 0, eo, ee}));
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("back_idle", 32'({rsp_valid, req_ready}), 32'(2'b01));
    endtask

    initial begin
        logic [5:0] ops [6];
        int         seen;
        logic [31:0] ra, rb;
        ops = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0};
        repeat (2) @(posedge clk);
        #1;
        check("rst_out", {rsp_result[30:0], rsp_valid}, 0);
        check("rst_flags", 32'({rsp_zero, rsp_ovf, rsp_err, req_ready}), 32'(4'b0001));
        check("rst_slice", 32'({slice_sel, slice_a, slice_b, slice_binv, slice_cin, slice_less}), 0);
        rst = 1'b0;
        run_op(6'd32, 32'd5, 32'd7, 0);
        run_op(6'd34, 32'd3, 32'd5, 0);
        run_op(6'd32, 32'h7FFFFFFF, 32'd1, 0);
        run_op(6'd42, 32'hFFFFFFFF, 32'd1, 0);
        run_op(6'd42, 32'h7FFFFFFF, 32'h80000000, 0);
        run_op(6'd42, 32'd9, 32'd9, 0);
        run_op(6'd36, 32'hF0F0F0F0, 32'hFF00FF00, 5);
        run_op(6'd37, 32'hF0F0F0F0, 32'hFF00FF00, 5);
        run_op(6'h27, 32'h12345678, 32'h9ABCDEF0, 0);
        // reset while the slice is on bit 10
        req_funct = 6'd32; req_a = $urandom; req_b = $urandom; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort_state", 32'({req_ready, rsp_valid}), 32'(2'b10));
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        check("abort_no_rsp", 32'(seen), 0);
        run_op(6'd32, 32'd1, 32'd1, 0);
        repeat (24) begin
            ra = $urandom;
            rb = ($urandom_range(0, 4) == 0) ? ra : $urandom;
            run_op(ops[$urandom_range(0, 5)], ra, rb, $urandom_range(0, 2));
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
